// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package binary_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned ADJ_THRESH = 5;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import binary_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= DIGIT_W'(ADJ_THRESH)) ? digit_i + DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle shift-and-add-3 binary to packed-BCD converter, one bit per clock.
module binary_to_bcd_seq
  import binary_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           value,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*DIGITS-1:0]  bcd,
  output logic                       overflow
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

  state_e            state_q, state_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [BCD_W-1:0]  scratch_adj;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              overflow_q, overflow_d;

  // Per-digit correction applied before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      scratch_q  <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scratch_q  <= scratch_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scratch_d  = scratch_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d    = value;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_W'(WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Any bit leaving the top digit means the result needs more digits.
        scratch_d = {scratch_adj[BCD_W-2:0], opnd_q[WIDTH-1]};
        opnd_d    = opnd_q << 1;
        ovf_d     = ovf_q | scratch_adj[BCD_W-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d      = ovf_q ? NINES : scratch_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench: default 10-bit/4-digit converter plus a 14-bit instance for saturation.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, busy_a, done_a, ovf_a;
  logic [9:0]  value_a;
  logic [15:0] bcd_a;

  logic        rst_b, start_b, busy_b, done_b, ovf_b;
  logic [13:0] value_b;
  logic [15:0] bcd_b;

  binary_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .value(value_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
  );

  binary_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .value(value_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion and check latency, busy window, result and hold behaviour.
  task automatic convert(input bit on_b, input int unsigned val, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int lat;
    int busy_cnt;
    int exp_lat;
    bit seen;
    exp_lat = on_b ? 15 : 11;
    if (on_b) begin start_b = 1'b1; value_b = 14'(val); end
    else      begin start_a = 1'b1; value_a = 10'(val); end
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    value_a = 10'($urandom);
    value_b = 14'($urandom);
    chk({tag, "_hold_prev"}, 32'(on_b ? bcd_b : bcd_a), 32'(on_b ? last_b : last_a));
    lat = 0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (on_b ? busy_b : busy_a) busy_cnt++;
      step();
      lat++;
      if (on_b ? done_b : done_a) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({tag, "_bcd"}, 32'(on_b ? bcd_b : bcd_a), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(on_b ? ovf_b : ovf_a), 32'(exp_ovf));
    step();
    chk({tag, "_done_pulse"}, 32'(on_b ? done_b : done_a), 32'd0);
    chk({tag, "_bcd_hold"}, 32'(on_b ? bcd_b : bcd_a), 32'(exp_bcd));
    if (on_b) last_b = exp_bcd;
    else      last_a = exp_bcd;
  endtask

  initial begin
    int n_done;
    rst_a = 1'b1; start_a = 1'b0; value_a = '0;
    rst_b = 1'b1; start_b = 1'b0; value_b = '0;
    step();
    step();
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_bcd_a",  32'(bcd_a),  32'd0);
    chk("rst_ovf_a",  32'(ovf_a),  32'd0);
    chk("rst_bcd_b",  32'(bcd_b),  32'd0);

    // Reset wins over a simultaneous start.
    start_a = 1'b1;
    value_a = 10'd5;
    step();
    chk("rst_over_start_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    start_a = 1'b0;
    step();

    convert(1'b0, 3,    16'h0003, 1'b0, "v3");
    convert(1'b0, 0,    16'h0000, 1'b0, "v0");
    convert(1'b0, 33,   16'h0033, 1'b0, "v33");
    convert(1'b0, 333,  16'h0333, 1'b0, "v333");
    convert(1'b0, 1011, 16'h1011, 1'b0, "v1011");
    convert(1'b0, 1000, 16'h1000, 1'b0, "v1000");
    convert(1'b0, 1023, 16'h1023, 1'b0, "v1023");

    convert(1'b1, 12345, 16'h9999, 1'b1, "w14_12345");
    convert(1'b1, 9999,  16'h9999, 1'b0, "w14_9999");
    convert(1'b1, 16383, 16'h9999, 1'b1, "w14_16383");
    convert(1'b1, 10000, 16'h9999, 1'b1, "w14_10000");

    // Start held high: back-to-back conversions every WIDTH+2 cycles.
    start_a = 1'b1;
    value_a = 10'd500;
    step();
    n_done = 0;
    for (int k = 1; k <= 47; k++) begin
      step();
      chk($sformatf("stream_done_k%0d", k), 32'(done_a), 32'((k % 12) == 11));
      if (done_a) begin
        n_done++;
        chk($sformatf("stream_bcd_k%0d", k), 32'(bcd_a), 32'h0500);
      end
    end
    start_a = 1'b0;
    chk("stream_done_count", 32'(n_done), 32'd4);
    step();
    chk("stream_idle_busy", 32'(busy_a), 32'd0);
    chk("stream_idle_done", 32'(done_a), 32'd0);
    last_a = 16'h0500;

    // Reset mid-conversion aborts with no done pulse afterwards.
    start_a = 1'b1;
    value_a = 10'd777;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk("abort_busy_before", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_bcd",  32'(bcd_a),  32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done_a) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    last_a = 16'h0000;
    convert(1'b0, 42, 16'h0042, 1'b0, "v42_after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
